x86_instr_encoder: RTL and testbench
====================================

Name: x86_instr_encoder

Overview:
- Serializer that encodes one decoded-form x86-64 instruction back into machine-code bytes, one byte per cycle, over a valid/ready stream.
- Inverse of the decode/print path. Used by the self-check bench to round-trip decoder output and by the trace generator.
- Covers legacy-free encodings: optional REX, 1-3 opcode bytes, optional ModRM/SIB, disp8/disp32, and an immediate of 0/1/2/4/8 bytes.

Parameters:
- ENABLE_DISP8, 1: when 1, displacements in [-128,127] use the mod=01 disp8 form; when 0, every non-zero or forced displacement uses disp32.
- LEN_W, 5: width of the ins_len output.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder idle; accepts when in_valid && in_ready
- rex_w  in  1  REX.W requested
- opc  in  24  opcode bytes; byte i = opc[8*i+:8], byte 0 is emitted first
- opc_len  in  2  opcode byte count, 1..3 (0 is treated as 1)
- has_modrm  in  1  emit ModRM (and SIB/disp as required)
- reg_field  in  4  ModRM.reg incl. bit3 (REX.R)
- rm_kind  in  2  0 = register, 1 = memory, 2 = rip-relative, 3 = reserved (error)
- base_reg  in  4  rm register or memory base
- has_base  in  1  memory base present
- index_reg  in  4  memory index
- has_index  in  1  memory index present
- scale  in  2  log2 of the scale factor
- disp  in  32  signed displacement
- imm  in  64  immediate, emitted little-endian
- imm_size  in  4  immediate byte count: 0, 1, 2, 4 or 8
- out_valid  out  1  out_byte valid
- out_byte  out  8  encoded byte
- out_last  out  1  final byte of the instruction
- out_ready  in  1  downstream accepts the byte
- ins_len  out  LEN_W  byte count of the last completed instruction
- err  out  1  one-cycle pulse when an input is rejected

Behaviour:
- Reset (asynchronous, takes effect immediately): state = IDLE; out_valid = 0, out_byte = 0, out_last = 0, err = 0, ins_len = 0. in_ready = 1, since it is decoded from state == IDLE.
- On the accept cycle T, all inputs are registered and the encoding is computed. The first byte is valid at T+1.
- A byte advances only on out_valid && out_ready. While out_ready = 0, out_byte and out_last hold stable.
- FSM states: IDLE -> REX -> OPC -> MODRM -> SIB -> DISP -> IMM -> IDLE. States that are not needed are skipped. A down-counter sequences the multi-byte states OPC, DISP and IMM.
- REX byte = 0100WRXB, with R = reg_field[3], X = index_reg[3] & has_index, B = base_reg[3]. It is emitted only if rex_w or any of R/X/B is 1.
- ModRM for rm_kind 0: mod = 11, rm = base_reg[2:0]; no SIB, no displacement.
- ModRM for rm_kind 2: mod = 00, rm = 101, disp32. REX.B = 0 in this case.
- ModRM for rm_kind 1:
  - SIB is needed if !has_base, or has_index, or base_reg[2:0] = 100.
  - No base: mod = 00, SIB base = 101, disp32.
  - With base: use mod = 00 when disp == 0 and base_reg[2:0] != 101. Otherwise use mod = 01 (disp8) when it fits and ENABLE_DISP8 = 1. Otherwise use mod = 10 (disp32).
  - rbp/r13 base with disp 0 is therefore forced to disp8 = 00.
  - With SIB, rm = 100. SIB = scale : index : base, where index = 100 when !has_index.
- Error cases: has_index with index_reg = 0100 (rsp), or rm_kind = 3, while has_modrm. The instruction is accepted (consumed), err pulses at T+1, no bytes are emitted, state returns to IDLE, and ins_len is unchanged.
- out_last is asserted on the final emitted byte. ins_len is updated on the handshake of that byte.
- Maximum length is 1 + 3 + 1 + 1 + 4 + 8 = 18 bytes.
- After the last handshake the FSM enters IDLE, so in_ready = 1 on the next cycle. There is no input overlap.

Test Plan:
- rex_w = 1, opc = 0x89, reg = 0, rm_kind = 0, base = 3 -> bytes 48 89 C3; out_last on C3; ins_len = 3.
- rex_w = 1, opc = 0x8B, reg = 1, rm_kind = 1, base = 12, disp = 0x10 -> 49 8B 4C 24 10; ins_len = 5.
- opc = 0x8B, reg = 0, rm_kind = 2, disp = 0x00001000 -> 8B 05 00 10 00 00.
- opc = 0x8B, reg = 0, rm_kind = 1, base = 5, disp = 0 -> 8B 45 00. With ENABLE_DISP8 = 0 and disp = 0x10 -> 8B 85 10 00 00 00.
- opc = 0xB8, has_modrm = 0, imm = 0x12345678, imm_size = 4, out_ready low for 3 cycles after byte 2 -> B8 78 56 34 12; byte 78 held stable throughout the stall.
- has_index = 1, index_reg = 4 -> err high for exactly 1 cycle, out_valid stays 0. Separately, assert reset after 2 bytes of a 6-byte instruction -> out_valid = 0 immediately, in_ready = 1, and a fresh encode after reset is correct.

Source files
------------

// File: rtl/x86_instr_encoder.sv
// Encodes one decoded x86-64 instruction into machine-code bytes, one byte per cycle.
// Latency: first byte valid the cycle after accept. Bytes hold stable while out_ready is low.
module x86_instr_encoder #(
    parameter int ENABLE_DISP8 = 1,
    parameter int LEN_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             rex_w,
    input  logic [23:0]      opc,
    input  logic [1:0]       opc_len,
    input  logic             has_modrm,
    input  logic [3:0]       reg_field,
    input  logic [1:0]       rm_kind,
    input  logic [3:0]       base_reg,
    input  logic             has_base,
    input  logic [3:0]       index_reg,
    input  logic             has_index,
    input  logic [1:0]       scale,
    input  logic [31:0]      disp,
    input  logic [63:0]      imm,
    input  logic [3:0]       imm_size,
    output logic             out_valid,
    output logic [7:0]       out_byte,
    output logic             out_last,
    input  logic             out_ready,
    output logic [LEN_W-1:0] ins_len,
    output logic             err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REX   = 3'd1;
    localparam logic [2:0] S_OPC   = 3'd2;
    localparam logic [2:0] S_MODRM = 3'd3;
    localparam logic [2:0] S_SIB   = 3'd4;
    localparam logic [2:0] S_DISP  = 3'd5;
    localparam logic [2:0] S_IMM   = 3'd6;

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic        need_rex;
    logic [7:0]  rex_r;
    logic [23:0] opc_r;
    logic [1:0]  opc_n;
    logic        need_modrm;
    logic [7:0]  modrm_r;
    logic        need_sib;
    logic [7:0]  sib_r;
    logic [31:0] disp_r;
    logic [2:0]  disp_n;
    logic [63:0] imm_r;
    logic [3:0]  imm_n;
    logic [4:0]  len_r;

    // Encoding computed from the raw inputs, registered on the accept cycle
    logic [1:0]  c_opc_n;
    logic [3:0]  c_imm_n;
    logic [1:0]  c_mod;
    logic [2:0]  c_rm;
    logic        c_need_sib;
    logic [7:0]  c_sib;
    logic [2:0]  c_disp_n;
    logic        c_err;
    logic        c_fits;
    logic        c_rex_b;
    logic        c_rex_x;
    logic        c_need_rex;
    logic [7:0]  c_rex;
    logic [7:0]  c_modrm;
    logic [4:0]  c_len;

    always_comb begin
        c_opc_n    = (opc_len == 2'd0) ? 2'd1 : opc_len;
        case (imm_size)
            4'd1, 4'd2, 4'd4, 4'd8: c_imm_n = imm_size;
            default:                c_imm_n = 4'd0;
        endcase
        c_mod      = 2'b11;
        c_rm       = base_reg[2:0];
        c_need_sib = 1'b0;
        c_sib      = 8'd0;
        c_disp_n   = 3'd0;
        c_err      = 1'b0;
        c_rex_b    = base_reg[3];
        c_fits     = ($signed(disp) >= -32'sd128) && ($signed(disp) <= 32'sd127);
        if (has_modrm) begin
            case (rm_kind)
                2'd0: begin
                    c_mod = 2'b11;
                    c_rm  = base_reg[2:0];
                end
                2'd1: begin
                    c_need_sib = !has_base || has_index || (base_reg[2:0] == 3'b100);
                    if (!has_base) begin
                        c_mod    = 2'b00;
                        c_disp_n = 3'd4;
                    end else if ((disp == 32'd0) && (base_reg[2:0] != 3'b101)) begin
                        c_mod    = 2'b00;
                    end else if ((ENABLE_DISP8 != 0) && c_fits) begin
                        c_mod    = 2'b01;
                        c_disp_n = 3'd1;
                    end else begin
                        c_mod    = 2'b10;
                        c_disp_n = 3'd4;
                    end
                    c_rm  = c_need_sib ? 3'b100 : base_reg[2:0];
                    c_sib = {scale,
                             has_index ? index_reg[2:0] : 3'b100,
                             has_base  ? base_reg[2:0]  : 3'b101};
                end
                2'd2: begin
                    c_mod    = 2'b00;
                    c_rm     = 3'b101;
                    c_disp_n = 3'd4;
                    c_rex_b  = 1'b0;
                end
                default: c_err = 1'b1;
            endcase
            if (has_index && (index_reg == 4'b0100))
                c_err = 1'b1;
        end
        c_rex_x    = index_reg[3] & has_index;
        c_rex      = {4'b0100, rex_w, reg_field[3], c_rex_x, c_rex_b};
        c_need_rex = rex_w | reg_field[3] | c_rex_x | c_rex_b;
        c_modrm    = {c_mod, reg_field[2:0], c_rm};
        c_len      = {4'd0, c_need_rex} + {3'd0, c_opc_n} + {4'd0, has_modrm}
                   + {4'd0, c_need_sib} + {2'd0, c_disp_n} + {1'b0, c_imm_n};
    end

    // Successor chain: each stage falls through to the next stage that has bytes
    logic [2:0] ad_s, as_s, am_s, ao_s;
    logic [3:0] ad_c, as_c, am_c, ao_c;
    logic [2:0] n_state;
    logic [3:0] n_cnt;

    always_comb begin
        ad_s = (imm_n != 4'd0) ? S_IMM : S_IDLE;
        ad_c = (imm_n != 4'd0) ? (imm_n - 4'd1) : 4'd0;
        as_s = (disp_n != 3'd0) ? S_DISP : ad_s;
        as_c = (disp_n != 3'd0) ? ({1'b0, disp_n} - 4'd1) : ad_c;
        am_s = need_sib ? S_SIB : as_s;
        am_c = need_sib ? 4'd0 : as_c;
        ao_s = need_modrm ? S_MODRM : am_s;
        ao_c = need_modrm ? 4'd0 : am_c;

        n_state = S_IDLE;
        n_cnt   = 4'd0;
        case (state)
            S_REX: begin
                n_state = S_OPC;
                n_cnt   = {2'b00, opc_n} - 4'd1;
            end
            S_OPC: begin
                if (cnt != 4'd0) begin
                    n_state = S_OPC;
                    n_cnt   = cnt - 4'd1;
                end else begin
                    n_state = ao_s;
                    n_cnt   = ao_c;
                end
            end
            S_MODRM: begin
                n_state = am_s;
                n_cnt   = am_c;
            end
            S_SIB: begin
                n_state = as_s;
                n_cnt   = as_c;
            end
            S_DISP: begin
                if (cnt != 4'd0) begin
                    n_state = S_DISP;
                    n_cnt   = cnt - 4'd1;
                end else begin
                    n_state = ad_s;
                    n_cnt   = ad_c;
                end
            end
            S_IMM: begin
                if (cnt != 4'd0) begin
                    n_state = S_IMM;
                    n_cnt   = cnt - 4'd1;
                end
            end
            default: begin
                n_state = S_IDLE;
                n_cnt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            need_rex   <= 1'b0;
            rex_r      <= 8'd0;
            opc_r      <= 24'd0;
            opc_n      <= 2'd1;
            need_modrm <= 1'b0;
            modrm_r    <= 8'd0;
            need_sib   <= 1'b0;
            sib_r      <= 8'd0;
            disp_r     <= 32'd0;
            disp_n     <= 3'd0;
            imm_r      <= 64'd0;
            imm_n      <= 4'd0;
            len_r      <= 5'd0;
            ins_len    <= '0;
            err        <= 1'b0;
        end else begin
            err <= (state == S_IDLE) && in_valid && c_err;
            if (state == S_IDLE) begin
                if (in_valid && !c_err) begin
                    need_rex   <= c_need_rex;
                    rex_r      <= c_rex;
                    opc_r      <= opc;
                    opc_n      <= c_opc_n;
                    need_modrm <= has_modrm;
                    modrm_r    <= c_modrm;
                    need_sib   <= c_need_sib;
                    sib_r      <= c_sib;
                    disp_r     <= disp;
                    disp_n     <= c_disp_n;
                    imm_r      <= imm;
                    imm_n      <= c_imm_n;
                    len_r      <= c_len;
                    state      <= c_need_rex ? S_REX : S_OPC;
                    cnt        <= c_need_rex ? 4'd0 : ({2'b00, c_opc_n} - 4'd1);
                end
            end else if (out_ready) begin
                state <= n_state;
                cnt   <= n_cnt;
                if (n_state == S_IDLE)
                    ins_len <= LEN_W'(len_r);
            end
        end
    end

    // Down-counter maps to a little-endian byte index: idx = n - 1 - cnt
    logic [1:0] opc_idx;
    logic [2:0] disp_idx;
    logic [3:0] imm_idx;

    always_comb begin
        opc_idx  = opc_n - 2'd1 - cnt[1:0];
        disp_idx = disp_n - 3'd1 - cnt[2:0];
        imm_idx  = imm_n - 4'd1 - cnt;
        out_byte = 8'd0;
        case (state)
            S_REX:   out_byte = rex_r;
            S_OPC:   out_byte = opc_r[{opc_idx, 3'b000} +: 8];
            S_MODRM: out_byte = modrm_r;
            S_SIB:   out_byte = sib_r;
            S_DISP:  out_byte = disp_r[{disp_idx[1:0], 3'b000} +: 8];
            S_IMM:   out_byte = imm_r[{imm_idx[2:0], 3'b000} +: 8];
            default: out_byte = 8'd0;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state != S_IDLE);
    assign out_last  = out_valid && (n_state == S_IDLE);

endmodule

// File: tb/tb_x86_instr_encoder.sv
// Directed and randomized round-trip bench for x86_instr_encoder (disp8 on and off instances).
module tb_x86_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic        f_rex_w;
    logic [23:0] f_opc;
    logic [1:0]  f_opc_len;
    logic        f_has_modrm;
    logic [3:0]  f_reg;
    logic [1:0]  f_rm_kind;
    logic [3:0]  f_base;
    logic        f_has_base;
    logic [3:0]  f_index;
    logic        f_has_index;
    logic [1:0]  f_scale;
    logic [31:0] f_disp;
    logic [63:0] f_imm;
    logic [3:0]  f_imm_size;
    logic [1:0]  out_valid;
    logic [7:0]  out_byte [2];
    logic [1:0]  out_last;
    logic        out_ready;
    logic [4:0]  ins_len [2];
    logic [1:0]  err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    bit   exp_err;
    bit   exp_given;
    int   exp_len [2];

    always #5 clk = ~clk;

    x86_instr_encoder #(.ENABLE_DISP8(1), .LEN_W(5)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .rex_w(f_rex_w), .opc(f_opc), .opc_len(f_opc_len), .has_modrm(f_has_modrm),
        .reg_field(f_reg), .rm_kind(f_rm_kind), .base_reg(f_base), .has_base(f_has_base),
        .index_reg(f_index), .has_index(f_has_index), .scale(f_scale), .disp(f_disp),
        .imm(f_imm), .imm_size(f_imm_size), .out_valid(out_valid[0]), .out_byte(out_byte[0]),
        .out_last(out_last[0]), .out_ready(out_ready), .ins_len(ins_len[0]), .err(err[0])
    );

    x86_instr_encoder #(.ENABLE_DISP8(0), .LEN_W(5)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .rex_w(f_rex_w), .opc(f_opc), .opc_len(f_opc_len), .has_modrm(f_has_modrm),
        .reg_field(f_reg), .rm_kind(f_rm_kind), .base_reg(f_base), .has_base(f_has_base),
        .index_reg(f_index), .has_index(f_has_index), .scale(f_scale), .disp(f_disp),
        .imm(f_imm), .imm_size(f_imm_size), .out_valid(out_valid[1]), .out_byte(out_byte[1]),
        .out_last(out_last[1]), .out_ready(out_ready), .ins_len(ins_len[1]), .err(err[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: builds the byte list straight from the x86 addressing rules
    task automatic build_expected(input bit d8);
        int nopc, dlen, sd;
        logic [1:0] md;
        logic [2:0] rm;
        bit use_sib, rb, rx;
        logic [7:0] rex, sibb;
        exp_q.delete();
        exp_err = f_has_modrm && ((f_rm_kind == 2'd3) || (f_has_index && f_index == 4'd4));
        if (exp_err) return;
        nopc = (f_opc_len == 0) ? 1 : int'(f_opc_len);
        rb  = (f_has_modrm && f_rm_kind == 2'd2) ? 1'b0 : f_base[3];
        rx  = f_has_index & f_index[3];
        rex = 8'h40 + (f_rex_w ? 8'd8 : 8'd0) + (f_reg[3] ? 8'd4 : 8'd0)
                    + (rx ? 8'd2 : 8'd0) + (rb ? 8'd1 : 8'd0);
        if (rex != 8'h40) exp_q.push_back(rex);
        for (int i = 0; i < nopc; i++) exp_q.push_back(f_opc[8*i +: 8]);
        if (f_has_modrm) begin
            dlen = 0; use_sib = 0; sibb = 8'h00;
            sd = $signed(f_disp);
            md = 2'd3; rm = f_base[2:0];
            if (f_rm_kind == 2'd2) begin
                md = 2'd0; rm = 3'd5; dlen = 4;
            end else if (f_rm_kind == 2'd1) begin
                use_sib = !f_has_base || f_has_index || (f_base[2:0] == 3'd4);
                if (!f_has_base) begin md = 2'd0; dlen = 4; end
                else if (sd == 0 && f_base[2:0] != 3'd5) md = 2'd0;
                else if (d8 && sd >= -128 && sd <= 127) begin md = 2'd1; dlen = 1; end
                else begin md = 2'd2; dlen = 4; end
                if (use_sib) rm = 3'd4;
                sibb = {f_scale, f_has_index ? f_index[2:0] : 3'd4, f_has_base ? f_base[2:0] : 3'd5};
            end
            exp_q.push_back({md, f_reg[2:0], rm});
            if (use_sib) exp_q.push_back(sibb);
            for (int i = 0; i < dlen; i++) exp_q.push_back(f_disp[8*i +: 8]);
        end
        for (int i = 0; i < int'(f_imm_size); i++) exp_q.push_back(f_imm[8*i +: 8]);
    endtask

    task automatic run_one(input int which, input int stall_at, input bit rnd_ready);
        int idx, cyc, stall_left;
        bit rdy;
        if (!exp_given) build_expected(which == 0);
        exp_given = 0;
        @(negedge clk);
        chk("in_ready_before", in_ready[which], 1);
        in_valid[which] = 1'b1;
        @(negedge clk);
        in_valid[which] = 1'b0;
        if (exp_err) begin
            chk("err_pulse", err[which], 1);
            chk("err_no_valid", out_valid[which], 0);
            @(negedge clk);
            chk("err_one_cycle", err[which], 0);
            chk("err_still_no_valid", out_valid[which], 0);
            chk("err_in_ready", in_ready[which], 1);
            chk("err_ins_len_kept", ins_len[which], exp_len[which]);
            return;
        end
        chk("first_byte_valid", out_valid[which], 1);
        chk("no_err", err[which], 0);
        idx = 0; cyc = 0; stall_left = 3;
        while (idx < exp_q.size() && cyc < 300) begin
            if (idx == stall_at && stall_left > 0) begin
                rdy = 1'b0; stall_left--;
            end else begin
                rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            out_ready = rdy;
            if (out_valid[which]) begin
                chk($sformatf("byte%0d", idx), out_byte[which], exp_q[idx]);
                chk($sformatf("last%0d", idx), out_last[which], idx == exp_q.size() - 1);
                if (rdy) idx++;
            end else begin
                chk("valid_dropped", out_valid[which], 1);
            end
            @(negedge clk);
            cyc++;
        end
        chk("all_bytes_seen", idx, exp_q.size());
        chk("ins_len", ins_len[which], exp_q.size());
        chk("idle_out_valid", out_valid[which], 0);
        chk("idle_in_ready", in_ready[which], 1);
        exp_len[which] = exp_q.size();
    endtask

    task automatic clear_fields();
        f_rex_w = 0; f_opc = 24'h0; f_opc_len = 2'd1; f_has_modrm = 1; f_reg = 4'd0;
        f_rm_kind = 2'd0; f_base = 4'd0; f_has_base = 1; f_index = 4'd0; f_has_index = 0;
        f_scale = 2'd0; f_disp = 32'd0; f_imm = 64'd0; f_imm_size = 4'd0;
    endtask

    task automatic random_fields();
        int sizes[5] = '{0, 1, 2, 4, 8};
        f_rex_w     = 1'($urandom_range(0, 1));
        f_opc       = 24'($urandom);
        f_opc_len   = 2'($urandom_range(0, 3));
        f_has_modrm = ($urandom_range(0, 3) != 0);
        f_reg       = 4'($urandom_range(0, 15));
        f_rm_kind   = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 19) == 0) f_rm_kind = 2'd3;
        f_base      = 4'($urandom_range(0, 15));
        f_has_base  = ($urandom_range(0, 3) != 0);
        f_has_index = (f_rm_kind == 2'd1) && ($urandom_range(0, 1) == 1);
        f_index     = 4'($urandom_range(0, 15));
        if (f_index == 4'd4 && $urandom_range(0, 3) != 0) f_index = 4'd6;
        f_scale     = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0: f_disp = 32'd0;
            1: f_disp = 32'($urandom_range(0, 255)) - 32'd128;
            2: f_disp = $urandom;
            default: begin
                case ($urandom_range(0, 3))
                    0: f_disp = 32'hFFFF_FF80;
                    1: f_disp = 32'hFFFF_FF7F;
                    2: f_disp = 32'h0000_007F;
                    default: f_disp = 32'h0000_0080;
                endcase
            end
        endcase
        f_imm      = {$urandom, $urandom};
        f_imm_size = 4'(sizes[$urandom_range(0, 4)]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 2'b00; out_ready = 1'b0;
        exp_given = 0; exp_len[0] = 0; exp_len[1] = 0;
        clear_fields();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", out_valid[k], 0);
            chk("rst_in_ready", in_ready[k], 1);
            chk("rst_out_byte", out_byte[k], 0);
            chk("rst_out_last", out_last[k], 0);
            chk("rst_err", err[k], 0);
            chk("rst_ins_len", ins_len[k], 0);
        end
        @(negedge clk); reset = 1'b0;

        // mov rbx, rax with REX.W
        clear_fields(); f_rex_w = 1; f_opc = 24'h89; f_base = 4'd3;
        exp_q = '{8'h48, 8'h89, 8'hC3}; exp_err = 0; exp_given = 1;
        run_one(0, -1, 0);

        // r12 base forces SIB, disp8
        clear_fields(); f_rex_w = 1; f_opc = 24'h8B; f_reg = 4'd1; f_rm_kind = 2'd1;
        f_base = 4'd12; f_disp = 32'h10;
        exp_q = '{8'h49, 8'h8B, 8'h4C, 8'h24, 8'h10}; exp_err = 0; exp_given = 1;
        run_one(0, -1, 0);

        clear_fields(); f_opc = 24'h8B; f_rm_kind = 2'd2; f_disp = 32'h0000_1000;
        exp_q = '{8'h8B, 8'h05, 8'h00, 8'h10, 8'h00, 8'h00}; exp_err = 0; exp_given = 1;
        run_one(0, -1, 0);

        // rbp base with zero displacement still needs a disp8
        clear_fields(); f_opc = 24'h8B; f_rm_kind = 2'd1; f_base = 4'd5;
        exp_q = '{8'h8B, 8'h45, 8'h00}; exp_err = 0; exp_given = 1;
        run_one(0, -1, 0);

        f_disp = 32'h10;
        exp_q = '{8'h8B, 8'h85, 8'h10, 8'h00, 8'h00, 8'h00}; exp_err = 0; exp_given = 1;
        run_one(1, -1, 0);

        clear_fields(); f_opc = 24'hB8; f_has_modrm = 0; f_imm = 64'h1234_5678; f_imm_size = 4'd4;
        exp_q = '{8'hB8, 8'h78, 8'h56, 8'h34, 8'h12}; exp_err = 0; exp_given = 1;
        run_one(0, 1, 0);

        clear_fields(); f_rm_kind = 2'd1; f_opc = 24'h8B; f_has_index = 1; f_index = 4'd4;
        run_one(0, -1, 0);
        clear_fields(); f_rm_kind = 2'd3; f_opc = 24'h8B;
        run_one(1, -1, 0);

        for (int n = 0; n < 60; n++) begin
            random_fields();
            run_one(n % 2, -1, 1);
        end

        // Async reset in the middle of a 6-byte instruction
        clear_fields(); f_opc = 24'h8B; f_rm_kind = 2'd2; f_disp = 32'h0000_1000;
        @(negedge clk); in_valid[0] = 1'b1;
        @(negedge clk); in_valid[0] = 1'b0; out_ready = 1'b1;
        chk("pre_rst_byte0", out_byte[0], 8'h8B);
        @(negedge clk);
        chk("pre_rst_byte1", out_byte[0], 8'h05);
        @(negedge clk);
        chk("pre_rst_valid", out_valid[0], 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid[0], 0);
        chk("mid_rst_in_ready", in_ready[0], 1);
        chk("mid_rst_out_byte", out_byte[0], 0);
        chk("mid_rst_ins_len", ins_len[0], 0);
        @(negedge clk); reset = 1'b0;
        exp_len[0] = 0; exp_len[1] = 0;

        clear_fields(); f_rex_w = 1; f_opc = 24'h8B; f_reg = 4'd1; f_rm_kind = 2'd1;
        f_base = 4'd12; f_disp = 32'h10;
        exp_q = '{8'h49, 8'h8B, 8'h4C, 8'h24, 8'h10}; exp_err = 0; exp_given = 1;
        run_one(0, -1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
